config_loader: RTL and testbench

Configuration loader for the 3x3 logic grid. It sits directly upstream of `LogicGrid` and accepts the configuration bitstream as a stream of fixed-width words over a valid/ready handshake. It assembles the words into the grid's 1746-bit `config_in` vector and holds the grid in reset until a complete, optionally CRC-checked, image has been loaded.

---
 rtl/kfpga_config_pkg.sv | 22 ++
 rtl/crc16_word.sv | 20 ++
 rtl/config_loader.sv | 108 ++++++++++
 tb/tb_config_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/kfpga_config_pkg.sv
// rtl/kfpga_config_pkg.sv - shared constants, state enum and CRC parameters for the config loader
package kfpga_config_pkg;

    localparam int CONFIG_WIDTH = 1746;
    localparam int WORD_WIDTH   = 32;
    localparam int WORD_COUNT   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SHIFT_WIDTH  = WORD_COUNT * WORD_WIDTH;

    localparam logic [5:0] LAST_WORD = 6'(WORD_COUNT - 1);

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

endpackage

// File: rtl/crc16_word.sv
// rtl/crc16_word.sv - combinational CRC-16-CCITT update over one 32-bit word, MSB first
module crc16_word
    import kfpga_config_pkg::*;
(
    input  logic [15:0]           crc_in,
    input  logic [WORD_WIDTH-1:0] data,
    output logic [15:0]           crc_out
);

    logic [15:0] crc_acc;

    always_comb begin
        crc_acc = crc_in;
        for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
            crc_acc = {crc_acc[14:0], 1'b0} ^ ((crc_acc[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - streams 32-bit words into the 1746-bit grid config; CONFIG_LOADER_CRC_EN adds a CRC-16 check word
module config_loader
    import kfpga_config_pkg::*;
(
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    cfg_start,
    input  logic [WORD_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    grid_nreset,
    output logic                    cfg_done,
    output logic                    cfg_error
);

    cfg_state_t             state;
    cfg_state_t             state_next;
    logic [5:0]             word_cnt;
    logic [SHIFT_WIDTH-1:0] shreg;
    logic                   accept;
    logic                   last_word;

    assign accept    = s_valid && s_ready;
    assign last_word = (word_cnt == LAST_WORD);

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic        crc_match;

    crc16_word u_crc16_word (
        .crc_in  (crc),
        .data    (s_data),
        .crc_out (crc_next)
    );

    assign crc_match = (s_data[15:0] == crc);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            crc <= CRC_INIT;
        end else if (cfg_start) begin
            crc <= CRC_INIT;
        end else if (accept && state == ST_LOAD) begin
            crc <= crc_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (accept && last_word) begin
`ifdef CONFIG_LOADER_CRC_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            ST_CHECK: begin
                s_ready = 1'b1;
                if (accept) begin
                    state_next = crc_match ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: ;
        endcase
        // A restart overrides everything, including a word accepted in the same cycle.
        if (cfg_start) begin
            state_next = ST_LOAD;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            shreg    <= '0;
        end else begin
            state <= state_next;
            if (cfg_start) begin
                word_cnt <= '0;
            end else if (accept && state == ST_LOAD) begin
                shreg <= {s_data, shreg[SHIFT_WIDTH-1:WORD_WIDTH]};
                if (!last_word) begin
                    word_cnt <= word_cnt + 6'd1;
                end
            end
        end
    end

    assign config_out  = shreg[CONFIG_WIDTH-1:0];
    assign grid_nreset = (state == ST_DONE);
    assign cfg_done    = (state == ST_DONE);
`ifdef CONFIG_LOADER_CRC_EN
    assign cfg_error   = (state == ST_ERROR);
`else
    assign cfg_error   = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - directed table-driven bench for config_loader
module tb_config_loader;
    import kfpga_config_pkg::*;

    logic                    clock = 1'b0;
    logic                    nreset = 1'b0;
    logic                    cfg_start = 1'b0;
    logic [WORD_WIDTH-1:0]   s_data = '0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [CONFIG_WIDTH-1:0] config_out;
    logic                    grid_nreset;
    logic                    cfg_done;
    logic                    cfg_error;

    config_loader dut (
        .clock       (clock),
        .nreset      (nreset),
        .cfg_start   (cfg_start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .config_out  (config_out),
        .grid_nreset (grid_nreset),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error)
    );

    always #5 clock = ~clock;

`ifdef CONFIG_LOADER_CRC_EN
    localparam int EXP_CYC = 56;
    localparam int EXP_TOG = 111;
`else
    localparam int EXP_CYC = 55;
    localparam int EXP_TOG = 109;
`endif

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } slice_vec_t;

    slice_vec_t              vecs[$];
    int                      errors = 0;
    int                      checks = 0;
    int                      cyc;
    int                      rdy;
    logic [CONFIG_WIDTH-1:0] saved;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_crc(input logic [15:0] c_in, input logic [31:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 31; i >= 0; i--) begin
            c = c ^ {d[i], 15'b0};
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] get_slice(input int i);
        if (i < 54) return config_out[i*32 +: 32];
        return {14'b0, config_out[1745:1728]};
    endfunction

    task automatic check_slices(input string tag);
        foreach (vecs[i]) begin
            check($sformatf("%s_slice%0d", tag, vecs[i].idx), get_slice(vecs[i].idx), vecs[i].exp);
        end
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
    endtask

    // Drives nwords data words (index k or a fixed value); a full load in CRC builds also sends the check word.
    task automatic run_load(input bit toggle, input bit use_fixed, input logic [31:0] fixed,
                            input int nwords, input logic [15:0] crc_flip,
                            output int cycles, output int ready_cycles);
        int          k;
        bit          sent;
        logic [31:0] d;
        logic [15:0] crc;
        k = 0;
        sent = 1'b0;
        crc = 16'hFFFF;
        cycles = 0;
        ready_cycles = 0;
        while (k < nwords && cycles < 400) begin
            d = use_fixed ? fixed : 32'(k);
            s_data = d;
            s_valid = !toggle || (cycles % 2 == 0);
            if (s_ready) ready_cycles++;
            if (s_valid && s_ready) begin
                crc = model_crc(crc, d);
                k++;
            end
            @(negedge clock);
            cycles++;
        end
`ifdef CONFIG_LOADER_CRC_EN
        if (nwords == WORD_COUNT) begin
            while (!sent && cycles < 400) begin
                s_data = {16'h0, crc ^ crc_flip};
                s_valid = !toggle || (cycles % 2 == 0);
                if (s_ready) ready_cycles++;
                if (s_valid && s_ready) sent = 1'b1;
                @(negedge clock);
                cycles++;
            end
        end
`endif
        s_valid = 1'b0;
        if (cycles >= 400) check("load_timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_s_ready", s_ready, 0);
        check("rst_config_out", config_out == '0, 1);
        check("rst_grid_nreset", grid_nreset, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_cfg_error", cfg_error, 0);
        nreset = 1'b1;
        @(negedge clock);
        check("idle_s_ready", s_ready, 0);

        // Back-to-back load of index-valued words
        pulse_start();
        check("start_s_ready", s_ready, 1);
        run_load(1'b0, 1'b0, 32'h0, WORD_COUNT, 16'h0, cyc, rdy);
        check("b2b_cycles", cyc, EXP_CYC);
        check("b2b_ready_cycles", rdy, EXP_CYC);
        check("b2b_cfg_done", cfg_done, 1);
        check("b2b_grid_nreset", grid_nreset, 1);
        check("b2b_cfg_error", cfg_error, 0);
        vecs = '{'{0, 32'd0}, '{1, 32'd1}, '{27, 32'd27}, '{53, 32'd53}, '{54, 32'd54}};
        check_slices("b2b");

        // Words offered after DONE are refused and the image holds
        saved = config_out;
        s_data = 32'hFFFF_FFFF;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("done_s_ready%0d", i), s_ready, 0);
            @(negedge clock);
        end
        s_valid = 1'b0;
        check("done_hold_config", config_out == saved, 1);
        check("done_hold_cfg_done", cfg_done, 1);

        // Same image with s_valid toggling
        pulse_start();
        check("restart_cfg_done", cfg_done, 0);
        check("restart_grid_nreset", grid_nreset, 0);
        run_load(1'b1, 1'b0, 32'h0, WORD_COUNT, 16'h0, cyc, rdy);
        check("tog_cycles", cyc, EXP_TOG);
        check("tog_cfg_done", cfg_done, 1);
        check_slices("tog");

        // Restart after 20 words, then a fresh constant image
        pulse_start();
        run_load(1'b0, 1'b0, 32'h0, 20, 16'h0, cyc, rdy);
        check("partial_cfg_done", cfg_done, 0);
        pulse_start();
        run_load(1'b0, 1'b1, 32'hA5A5_A5A5, WORD_COUNT, 16'h0, cyc, rdy);
        check("a5_cfg_done", cfg_done, 1);
        vecs.delete();
        for (int i = 0; i < 54; i++) vecs.push_back('{i, 32'hA5A5_A5A5});
        vecs.push_back('{54, 32'h0001_A5A5});
        check_slices("a5");

        // Asynchronous reset in the middle of a load
        pulse_start();
        run_load(1'b0, 1'b0, 32'h0, 30, 16'h0, cyc, rdy);
        #2 nreset = 1'b0;
        #1;
        check("arst_config_out", config_out == '0, 1);
        check("arst_s_ready", s_ready, 0);
        check("arst_grid_nreset", grid_nreset, 0);
        check("arst_cfg_done", cfg_done, 0);
        @(negedge clock);
        nreset = 1'b1;
        s_data = 32'h1234_5678;
        s_valid = 1'b1;
        check("arst_idle_s_ready", s_ready, 0);
        @(negedge clock);
        s_valid = 1'b0;
        check("arst_no_accept", config_out == '0, 1);

`ifdef CONFIG_LOADER_CRC_EN
        pulse_start();
        run_load(1'b0, 1'b1, 32'h0, WORD_COUNT, 16'h0, cyc, rdy);
        check("crc_ok_cfg_done", cfg_done, 1);
        check("crc_ok_grid_nreset", grid_nreset, 1);
        check("crc_ok_cfg_error", cfg_error, 0);
        check("crc_zero_value", model_crc(16'hFFFF, 32'h0) != 16'h0, 1);
        pulse_start();
        run_load(1'b0, 1'b1, 32'h0, WORD_COUNT, 16'h0001, cyc, rdy);
        check("crc_bad_cfg_error", cfg_error, 1);
        check("crc_bad_grid_nreset", grid_nreset, 0);
        check("crc_bad_cfg_done", cfg_done, 0);
        check("crc_bad_s_ready", s_ready, 0);
        pulse_start();
        check("crc_clear_cfg_error", cfg_error, 0);
        check("crc_clear_s_ready", s_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
